// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline, with mult/div busy sequencing.
// Optional stall-cycle performance counter enabled by defining HFC_PERF_CNT_EN.
module hazard_forward_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  a3_D,
    input  logic [1:0]  res_D,
    input  logic [1:0]  md_op_D,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwd_rs_E_src,
    output logic [1:0]  fwd_rt_E_src,
    output logic [31:0] stall_cnt
);
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_ALU  = 2'd1;
    localparam logic [1:0] RES_LOAD = 2'd2;
    localparam logic [1:0] RES_LINK = 2'd3;

    localparam logic [1:0] MD_NONE = 2'd0;
    localparam logic [1:0] MD_MULT = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;

    localparam logic [1:0] SEL_RD   = 2'd0;
    localparam logic [1:0] SEL_AO   = 2'd1;
    localparam logic [1:0] SEL_PC8  = 2'd2;
    localparam logic [1:0] SEL_WD   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    logic [4:0]       r_rs_E, r_rt_E, r_a3_E, r_a3_M, r_a3_W;
    logic [1:0]       r_res_E, r_res_M, r_res_W, r_md_E;
    logic [CNT_W-1:0] r_busy_cnt;

    logic       w_live_E, w_live_M, w_live_W;
    logic [1:0] w_tnew_E, w_tnew_M;
    logic       w_md_hz, w_md_start;
    logic [1:0] w_hz;
    logic [4:0] w_src_D [2];
    logic [1:0] w_tuse_D [2];
    logic [4:0] w_src_E [2];
    logic [1:0] w_fwd [2];

    assign w_live_E = (r_a3_E != 5'd0) && (r_res_E != RES_NONE);
    assign w_live_M = (r_a3_M != 5'd0) && (r_res_M != RES_NONE);
    assign w_live_W = (r_a3_W != 5'd0) && (r_res_W != RES_NONE);

    // Cycles until the producer's result reaches a forwardable stage.
    assign w_tnew_E = (r_res_E == RES_LOAD) ? 2'd2 :
                      (r_res_E == RES_NONE) ? 2'd0 : 2'd1;
    assign w_tnew_M = (r_res_M == RES_LOAD) ? 2'd1 : 2'd0;

    assign w_src_D[0]  = rs_D;
    assign w_src_D[1]  = rt_D;
    assign w_tuse_D[0] = tuse_rs_D;
    assign w_tuse_D[1] = tuse_rt_D;
    assign w_src_E[0]  = r_rs_E;
    assign w_src_E[1]  = r_rt_E;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_hz[gi] = (w_src_D[gi] != 5'd0) && (w_tuse_D[gi] != 2'd3) &&
                              ((w_live_E && (r_a3_E == w_src_D[gi]) && (w_tnew_E > w_tuse_D[gi])) ||
                               (w_live_M && (r_a3_M == w_src_D[gi]) && (w_tnew_M > w_tuse_D[gi])));

            // A load sitting in M has no data yet, so it falls through to the W check.
            assign w_fwd[gi] =
                (w_src_E[gi] != 5'd0 && w_live_M && r_a3_M == w_src_E[gi] && r_res_M == RES_ALU)  ? SEL_AO  :
                (w_src_E[gi] != 5'd0 && w_live_M && r_a3_M == w_src_E[gi] && r_res_M == RES_LINK) ? SEL_PC8 :
                (w_src_E[gi] != 5'd0 && w_live_W && r_a3_W == w_src_E[gi])                        ? SEL_WD  :
                                                                                                    SEL_RD;
        end
    endgenerate

    assign w_md_start   = (r_md_E == MD_MULT) || (r_md_E == MD_DIV);
    assign w_md_hz      = (md_op_D != MD_NONE) && ((r_busy_cnt != '0) || w_md_start);
    assign stall        = w_hz[0] | w_hz[1] | w_md_hz;
    assign fwd_rs_E_src = w_fwd[0];
    assign fwd_rt_E_src = w_fwd[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs_E  <= '0;
            r_rt_E  <= '0;
            r_a3_E  <= '0;
            r_res_E <= '0;
            r_md_E  <= '0;
            r_a3_M  <= '0;
            r_res_M <= '0;
            r_a3_W  <= '0;
            r_res_W <= '0;
        end else begin
            r_a3_W  <= r_a3_M;
            r_res_W <= r_res_M;
            r_a3_M  <= flush ? 5'd0 : r_a3_E;
            r_res_M <= flush ? RES_NONE : r_res_E;
            if (stall || flush) begin
                r_rs_E  <= '0;
                r_rt_E  <= '0;
                r_a3_E  <= '0;
                r_res_E <= '0;
                r_md_E  <= '0;
            end else begin
                r_rs_E  <= rs_D;
                r_rt_E  <= rt_D;
                r_a3_E  <= a3_D;
                r_res_E <= res_D;
                r_md_E  <= md_op_D;
            end
        end
    end

    // The unit keeps counting through a flush; only a flushed start is suppressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_cnt <= '0;
        end else if (r_md_E == MD_MULT && !flush) begin
            r_busy_cnt <= CNT_MULT;
        end else if (r_md_E == MD_DIV && !flush) begin
            r_busy_cnt <= CNT_DIV;
        end else if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - CNT_W'(1);
        end
    end

`ifdef HFC_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios plus randomized traffic,
// all checked every cycle against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] a3;
        logic [1:0] res;
        logic [1:0] md;
    } ins_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, a3_D;
    logic [1:0]  tuse_rs_D, tuse_rt_D, res_D, md_op_D;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_rs_E_src, fwd_rt_E_src;
    logic [31:0] stall_cnt;

    hazard_forward_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .a3_D(a3_D), .res_D(res_D),
        .md_op_D(md_op_D), .flush(flush), .stall(stall),
        .fwd_rs_E_src(fwd_rs_E_src), .fwd_rt_E_src(fwd_rt_E_src), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: instruction slots E=0, M=1, W=2; MDU busy as an absolute end cycle.
    ins_t        m_pipe [3];
    longint      m_cyc;
    longint      m_busy_end;
    logic [31:0] m_perf;

    logic        obs_stall;
    logic [1:0]  obs_rs, obs_rt;
    logic [31:0] obs_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    function automatic ins_t mk(input int rs, input int rt, input int trs, input int trt,
                                input int a3, input int res, input int md);
        ins_t x;
        x.rs = 5'(rs); x.rt = 5'(rt); x.tuse_rs = 2'(trs); x.tuse_rt = 2'(trt);
        x.a3 = 5'(a3); x.res = 2'(res); x.md = 2'(md);
        return x;
    endfunction

    function automatic bit live(input ins_t x);
        return (x.a3 != 0) && (x.res != 0);
    endfunction

    // Result becomes available at stage M (1) for ALU/LINK, W (2) for LOAD.
    function automatic int tnew_of(input ins_t x, input int s);
        int rdy;
        rdy = (x.res == 2) ? 2 : ((x.res == 0) ? 0 : 1);
        return (rdy > s) ? rdy - s : 0;
    endfunction

    function automatic bit hz_on(input logic [4:0] r, input logic [1:0] tuse);
        if (r == 0 || tuse == 3) return 1'b0;
        for (int s = 0; s < 2; s++)
            if (live(m_pipe[s]) && m_pipe[s].a3 == r && tnew_of(m_pipe[s], s) > int'(tuse))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] fwd_for(input logic [4:0] r);
        if (r == 0) return 2'd0;
        if (live(m_pipe[1]) && m_pipe[1].a3 == r) begin
            if (m_pipe[1].res == 1) return 2'd1;
            if (m_pipe[1].res == 3) return 2'd2;
        end
        if (live(m_pipe[2]) && m_pipe[2].a3 == r) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit model_stall(input ins_t d);
        bit md_hz;
        md_hz = (d.md != 0) && ((m_cyc < m_busy_end) || m_pipe[0].md == 1 || m_pipe[0].md == 2);
        return hz_on(d.rs, d.tuse_rs) || hz_on(d.rt, d.tuse_rt) || md_hz;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) m_pipe[s] = '0;
        m_busy_end = 0;
        m_perf = 32'd0;
    endtask

    // One clock cycle: drive D, compare at negedge, advance the model at posedge.
    task automatic step(input ins_t d, input bit fl, input bit rst, output bit exp_st);
        rs_D = d.rs; rt_D = d.rt; tuse_rs_D = d.tuse_rs; tuse_rt_D = d.tuse_rt;
        a3_D = d.a3; res_D = d.res; md_op_D = d.md; flush = fl; reset = rst;
        exp_st = model_stall(d);
        @(negedge clk);
        obs_stall = stall; obs_rs = fwd_rs_E_src; obs_rt = fwd_rt_E_src; obs_cnt = stall_cnt;
        check_eq("stall", {31'd0, stall}, {31'd0, exp_st});
        check_eq("fwd_rs", {30'd0, fwd_rs_E_src}, {30'd0, fwd_for(m_pipe[0].rs)});
        check_eq("fwd_rt", {30'd0, fwd_rt_E_src}, {30'd0, fwd_for(m_pipe[0].rt)});
        check_eq("stall_cnt", stall_cnt, m_perf);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
`ifdef HFC_PERF_CNT_EN
            if (exp_st && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
`endif
            if (!fl && m_pipe[0].md == 1) m_busy_end = m_cyc + 1 + MULT_CYCLES;
            if (!fl && m_pipe[0].md == 2) m_busy_end = m_cyc + 1 + DIV_CYCLES;
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = fl ? '0 : m_pipe[0];
            m_pipe[0] = (exp_st || fl) ? '0 : d;
        end
        m_cyc++;
        #1;
    endtask

    // Present d in D until it is accepted; returns the number of stall cycles.
    task automatic issue(input ins_t d, output int n);
        bit st;
        bit done;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(d, 1'b0, 1'b0, st);
            if (!st) done = 1'b1;
            else n++;
        end
        if (!done) check_eq("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        bit st;
        step('0, 1'b0, 1'b1, st);
    endtask

    ins_t nop, lw1, addu_use1, addu1, beq1, addu4, subu44, jal, addu31;
    ins_t mult, mflo, div, mfhi, zprod, zuse, cur;
    int   n;
    bit   st;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        nop       = mk(0, 0, 3, 3, 0, 0, 0);
        lw1       = mk(0, 0, 3, 3, 1, 2, 0);
        addu_use1 = mk(1, 3, 1, 1, 2, 1, 0);
        addu1     = mk(0, 0, 3, 3, 1, 1, 0);
        beq1      = mk(1, 0, 0, 3, 0, 0, 0);
        addu4     = mk(0, 0, 3, 3, 4, 1, 0);
        subu44    = mk(4, 4, 1, 1, 5, 1, 0);
        jal       = mk(0, 0, 3, 3, 31, 3, 0);
        addu31    = mk(31, 0, 1, 3, 6, 1, 0);
        mult      = mk(0, 0, 3, 3, 0, 0, 1);
        mflo      = mk(0, 0, 3, 3, 7, 1, 3);
        div       = mk(0, 0, 3, 3, 0, 0, 2);
        mfhi      = mk(0, 0, 3, 3, 8, 1, 3);
        zprod     = mk(0, 0, 3, 3, 0, 1, 0);
        zuse      = mk(0, 0, 1, 1, 9, 1, 0);

        reset = 1'b1; flush = 1'b0;
        rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
        a3_D = '0; res_D = '0; md_op_D = '0;
        repeat (2) @(posedge clk);
        #1;
        m_cyc = 0;
        model_clear();

        step(nop, 1'b0, 1'b0, st);
        check_eq("reset_stall", {31'd0, obs_stall}, 32'd0);
        check_eq("reset_fwd_rs", {30'd0, obs_rs}, 32'd0);
        check_eq("reset_cnt", obs_cnt, 32'd0);
        $display("scenario reset state");

        issue(lw1, n); issue(addu_use1, n);
        check_eq("lw_use_stalls", n, 1);
        step(nop, 1'b0, 1'b0, st);
        check_eq("lw_use_fwd_wd", {30'd0, obs_rs}, 32'd3);
        $display("scenario lw->addu stalls=%0d", n);

        do_reset();
        issue(lw1, n); issue(beq1, n);
        check_eq("lw_beq_stalls", n, 2);
        issue(addu1, n); issue(beq1, n);
        check_eq("addu_beq_stalls", n, 1);
        step(nop, 1'b0, 1'b0, st);
`ifdef HFC_PERF_CNT_EN
        check_eq("perf_cnt_3", obs_cnt, 32'd3);
`else
        check_eq("perf_cnt_off", obs_cnt, 32'd0);
`endif
        $display("scenario branch stalls, stall_cnt=%0d", obs_cnt);

        do_reset();
        issue(addu4, n); issue(subu44, n);
        check_eq("alu_alu_stalls", n, 0);
        step(nop, 1'b0, 1'b0, st);
        check_eq("alu_fwd_rs", {30'd0, obs_rs}, 32'd1);
        check_eq("alu_fwd_rt", {30'd0, obs_rt}, 32'd1);
        issue(jal, n); issue(addu31, n);
        step(nop, 1'b0, 1'b0, st);
        check_eq("link_fwd_rs", {30'd0, obs_rs}, 32'd2);
        $display("scenario alu/link forwarding");

        do_reset();
        issue(mult, n); issue(mflo, n);
        check_eq("mult_mflo_stalls", n, 1 + MULT_CYCLES);
        $display("scenario mult->mflo stalls=%0d", n);

        issue(div, n);
        step(mfhi, 1'b1, 1'b0, st);
        check_eq("div_flush_stall", {31'd0, obs_stall}, 32'd1);
        issue(mfhi, n);
        check_eq("div_flushed_mfhi", n, 0);
        $display("scenario flushed div");

        issue(mult, n);
        step(mflo, 1'b0, 1'b1, st);
        check_eq("mid_reset_stall", {31'd0, obs_stall}, 32'd1);
        issue(mflo, n);
        check_eq("after_reset_mflo", n, 0);
        $display("scenario reset during mult");

        issue(zprod, n); issue(zuse, n);
        check_eq("zero_reg_stalls", n, 0);
        step(nop, 1'b0, 1'b0, st);
        check_eq("zero_reg_fwd", {30'd0, obs_rs}, 32'd0);
        $display("scenario register zero");

        st = 1'b0;
        cur = nop;
        for (int i = 0; i < 800; i++) begin
            bit rst;
            bit fl;
            if (!st) begin
                cur.rs = 5'($urandom_range(0, 3));
                cur.rt = 5'($urandom_range(0, 3));
                cur.tuse_rs = 2'($urandom_range(0, 3));
                cur.tuse_rt = 2'($urandom_range(0, 3));
                cur.a3 = 5'($urandom_range(0, 3));
                cur.res = 2'($urandom_range(0, 3));
                cur.md = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            end
            rst = ($urandom_range(0, 96) == 0);
            fl  = ($urandom_range(0, 10) == 0);
            step(cur, fl, rst, st);
            if (rst) st = 1'b0;
        end
        $display("scenario random traffic, 800 cycles");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
